// File: rtl/x25519_pkg.sv
// x25519_pkg: constants and types shared by the Curve25519 field multiplier.
//   P_FIELD  : field prime 2^255 - 19
//   FOLD_38  : 2^256 mod p, used to fold the upper product half
//   FOLD_19  : 2^255 mod p, used to fold bits above 2^255
//   OP_W     : operand/result container width (33 bytes)
//   state_e  : controller states
package x25519_pkg;

  localparam int OP_W = 264;

  localparam logic [254:0] P_FIELD =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

  localparam logic [5:0] FOLD_38 = 6'd38;
  localparam logic [4:0] FOLD_19 = 5'd19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_FOLD1,
    ST_FOLD2,
    ST_FINAL
  } state_e;

endpackage

// File: rtl/x25519_reduce.sv
// x25519_reduce: reduces a 512-bit product modulo 2^255 - 19.
// Two internal registers line up with the controller phases:
//   ld_r1 (FOLD1) captures r1 = P[255:0] + 38*P[511:256]
//   ld_r2 (FOLD2) captures r2 = r1[254:0] + 19*r1[261:255]
// res is the combinational final conditional subtract of r2, sampled by
// the top level during FINAL.
// Ports: clk, rst_n, prod[511:0], ld_r1, ld_r2 -> res[254:0]
module x25519_reduce
  import x25519_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] prod,
  input  logic         ld_r1,
  input  logic         ld_r2,
  output logic [254:0] res
);

  logic [261:0] r1_q, r1_d;
  logic [255:0] r2_q, r2_d;
  logic         r2_ge_p;

  always_comb begin
    r1_d = r1_q;
    r2_d = r2_q;
    // 39 * (2^256 - 1) < 2^262, so 262 bits hold r1 without loss.
    if (ld_r1)
      r1_d = {6'b0, prod[255:0]} + ({6'b0, prod[511:256]} * 262'(FOLD_38));
    if (ld_r2)
      r2_d = {1'b0, r1_q[254:0]} + (256'(r1_q[261:255]) * 256'(FOLD_19));
  end

  // r2 < 2p, so one subtract fully reduces; the difference is below 2^255,
  // which makes the 255-bit wrap-around subtraction exact.
  assign r2_ge_p = (r2_q >= {1'b0, P_FIELD});
  assign res     = r2_ge_p ? (r2_q[254:0] - P_FIELD) : r2_q[254:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q <= '0;
      r2_q <= '0;
    end else begin
      r1_q <= r1_d;
      r2_q <= r2_d;
    end
  end

endmodule

// File: rtl/x25519_mult.sv
// x25519_mult: iterative multiplier out = (a * b) mod (2^255 - 19).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for en; operands latched and accumulator cleared
// ST_MAC   | 32 cycles, one 256x8 partial product per cycle
// ST_FOLD1 | reducer captures r1
// ST_FOLD2 | reducer captures r2
// ST_FINAL | reduced result registered on out, out_valid pulsed
//
// Ports: clk, rst_n (async, active low), en (start strobe),
//        a/b [263:0] operands (top byte ignored),
//        out_valid (1-cycle pulse), out [263:0] result in [0, p).
module x25519_mult
  import x25519_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic            out_valid,
  output logic [OP_W-1:0] out
);

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [255:0]    a_q, a_d;
  logic [255:0]    b_q, b_d;
  logic [511:0]    acc_q, acc_d;
  logic            out_valid_q, out_valid_d;
  logic [OP_W-1:0] out_q, out_d;

  logic            ld_r1, ld_r2;
  logic [254:0]    red_res;
  logic [7:0]      b_byte;
  logic [263:0]    pp;
  logic [511:0]    pp_sh;
  logic            unused_hi;

  // Container top bytes carry no information.
  assign unused_hi = ^{a[263:256], b[263:256]};

  assign b_byte = b_q[{cnt_q, 3'b000} +: 8];
  assign pp     = {8'b0, a_q} * {256'b0, b_byte};
  assign pp_sh  = {248'b0, pp} << {cnt_q, 3'b000};

  // Partial sums never exceed the final product (< 2^512), so the
  // accumulator needs no carry bit beyond 512.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    ld_r1       = 1'b0;
    ld_r2       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          a_d     = a[255:0];
          b_d     = b[255:0];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + pp_sh;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_FOLD1;
      end
      ST_FOLD1: begin
        ld_r1   = 1'b1;
        state_d = ST_FOLD2;
      end
      ST_FOLD2: begin
        ld_r2   = 1'b1;
        state_d = ST_FINAL;
      end
      ST_FINAL: begin
        out_d       = {9'b0, red_res};
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  x25519_reduce u_reduce (
    .clk   (clk),
    .rst_n (rst_n),
    .prod  (acc_q),
    .ld_r1 (ld_r1),
    .ld_r2 (ld_r2),
    .res   (red_res)
  );

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_x25519_mult.sv
module tb_x25519_mult;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [263:0] a, b;
  logic         out_valid;
  logic [263:0] out;

  int checks = 0;
  int errors = 0;

  localparam logic [511:0] PM = (512'd1 << 255) - 512'd19;

  always #5 clk = ~clk;

  x25519_mult dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out       (out)
  );

  task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [263:0] rnd_op();
    logic [263:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    v[263:256] = 8'($urandom());
    return v;
  endfunction

  // Reference: exact product then true modulus, ignoring container top bytes.
  function automatic logic [263:0] ref_mul(input logic [263:0] x, input logic [263:0] y);
    logic [511:0] pr;
    pr = {256'b0, x[255:0]} * {256'b0, y[255:0]};
    return 264'(pr % PM);
  endfunction

  // Issues an operation (caller is positioned just after a clock edge),
  // scrambles the inputs right after the start edge, and waits for out_valid.
  task automatic run_op(input logic [263:0] ta, input logic [263:0] tb_,
                        output logic [263:0] res, output int lat);
    a  = ta;
    b  = tb_;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    a  = rnd_op();
    b  = rnd_op();
    chk("valid_low_after_start", {263'b0, out_valid}, 264'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out;
  endtask

  initial begin
    logic [263:0] res, hold, x, y, got, exp_c;
    logic [263:0] ea[5];
    logic [263:0] eb[5];
    logic [263:0] ee[5];
    int lat, pulses;

    en = 1'b0; a = '0; b = '0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {263'b0, out_valid}, 264'd0);
    chk("reset_out", out, 264'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Known vector followed by back-to-back random operations.
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        x = 264'h00dc21740e549bcdab5e580525a3310d66c9332e76e71b547ce3f2ba294a516967;
        y = 264'h00873d418211b4c6b2d4e9175d5a58b7329a9f635a8de8f8c246fbabcdecff73c6;
      end else begin
        x = rnd_op();
        y = rnd_op();
      end
      run_op(x, y, res, lat);
      chk("latency", 264'(lat), 264'd35);
      chk("b2b_result", res, ref_mul(x, y));
      if (i == 0)
        chk("known_vector", res,
            264'h0073eb81412a74aa40262a3d10bbf09e7d735e1045a29a0f8f53932ac47f774d0e);
    end

    // Pulse is one cycle wide and out holds afterwards.
    hold = out;
    @(posedge clk); #1;
    chk("valid_pulse_width", {263'b0, out_valid}, 264'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("out_stable", out, hold);

    // Edge arithmetic.
    ea[0] = 264'd0;                    eb[0] = rnd_op();           ee[0] = 264'd0;
    ea[1] = 264'd1;                    eb[1] = PM[263:0];          ee[1] = 264'd0;
    ea[2] = PM[263:0] - 264'd1;        eb[2] = PM[263:0] - 264'd1; ee[2] = 264'd1;
    ea[3] = {8'h0, {256{1'b1}}};       eb[3] = 264'd1;             ee[3] = 264'd37;
    ea[4] = 264'd19;                   eb[4] = 264'd1 << 250;      ee[4] = 264'd19 << 250;
    for (int i = 0; i < 5; i++) begin
      run_op(ea[i], eb[i], res, lat);
      chk("edge_latency", 264'(lat), 264'd35);
      chk("edge_result", res, ee[i]);
      chk("edge_model", res, ref_mul(ea[i], eb[i]));
    end

    // en during MAC is ignored.
    @(posedge clk); #1;
    x = rnd_op();
    y = rnd_op();
    a = x; b = y; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    a = rnd_op(); b = rnd_op(); en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    pulses = 0;
    got = '0;
    for (int c = 0; c < 70; c++) begin
      if (out_valid === 1'b1) begin
        pulses++;
        got = out;
      end
      @(posedge clk); #1;
    end
    chk("busy_pulses", 264'(pulses), 264'd1);
    chk("busy_result", got, ref_mul(x, y));

    // Reset during MAC aborts.
    x = rnd_op();
    y = rnd_op();
    a = x; b = y; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {263'b0, out_valid}, 264'd0);
    chk("abort_out", out, 264'd0);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
    end
    chk("no_stale_valid", 264'(pulses), 264'd0);
    x = rnd_op();
    y = rnd_op();
    run_op(x, y, res, lat);
    chk("post_reset_latency", 264'(lat), 264'd35);
    chk("post_reset_result", res, ref_mul(x, y));

    // A few more random operations with sparse operand patterns.
    for (int i = 0; i < 4; i++) begin
      x = rnd_op();
      y = rnd_op();
      if (i[0]) x[255:128] = '0;
      if (i[1]) y = {8'h0, {256{1'b1}}};
      run_op(x, y, res, lat);
      chk("rand_result", res, ref_mul(x, y));
      exp_c = ref_mul(x, y);
      chk("rand_top_bits", {255'b0, res[263:255]}, {255'b0, exp_c[263:255]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
